i2s_tx_serializer: RTL and testbench
====================================

# i2s_tx_serializer

Audio output serializer that takes 32-bit signed filtered samples from the IIR filter over a valid/ready handshake and drives them to the audio codec as a standard Philips I2S stream. It saturates each sample to the codec data width and places the same mono sample on both the left and right channel slots. It generates BCLK and LRCLK from the system clock. It sits between the filter output and the codec pins.

## Interface
- CLK_DIV, 4: system clocks per BCLK half-period; legal values 2..255. Frame rate = f_clk / (128·CLK_DIV).
- DATA_W, 24: codec data width; legal values 8..32. Sent MSB-justified in a 32-bit slot.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- sample_in  input  32  signed sample from the filter.
- sample_valid  input  1  sample_in is valid.
- sample_ready  output  1  the holding register is empty and accepts a sample.
- bclk  output  1  I2S bit clock.
- lrclk  output  1  word select; 0 = left, 1 = right.
- sdata  output  1  serial data; changes only on BCLK falling edges.
- underrun  output  1  one-clk pulse when a frame loads with no sample available.

## Operation
- Holding register: one 32-bit entry plus a full flag. sample_ready = !full.
- A transfer occurs on a clk edge with sample_valid && sample_ready. It writes the entry and sets full.
- BCLK divider: div_cnt counts 0..CLK_DIV-1 on every clk. When the count wraps, bclk toggles.
- Falling event: the clk edge at which bclk toggles 1→0. bit_cnt (6 bits, 0..63) increments modulo 64 on each falling event.
- lrclk is driven on falling events:
  - lrclk is 0 while the new bit_cnt is 0..31.
  - lrclk is 1 while the new bit_cnt is 32..63.
- Frame word F = {S, S}, where S = {sat(sample), (32-DATA_W)'b0}.
- sat() clamps the signed 32-bit value:
  - Values above 2^(DATA_W-1)-1 become 2^(DATA_W-1)-1.
  - Values below -2^(DATA_W-1) become -2^(DATA_W-1).
  - All other values become their low DATA_W bits.
- Load event: the falling event at which bit_cnt goes 0→1. At this event:
  - If full: F is loaded from the holding entry, full is cleared, and sdata ← F[63].
  - If empty: F is 0, sdata ← 0, and underrun pulses high for exactly that clk.
- All other falling events shift the frame out: sdata ← next bit of F, MSB first. F[0] (right LSB) is driven at bit_cnt = 0 of the following frame. This gives the I2S one-BCLK delay after each lrclk edge: left MSB at bit_cnt 1, right MSB at bit_cnt 33.
- Simultaneous transfer and load event when empty:
  - The load uses the pre-edge state, so the frame is zero and underrun pulses.
  - The incoming sample lands in the holding register and is sent in the next frame.
- Simultaneous transfer and load event when full: impossible, because ready is low.
- Sample dropping: none. When the source is faster than the frame rate, back-pressure throttles it.

## Timing
- Reset values, applied immediately on reset = 0 and held while reset is low:
  - bclk = 0, lrclk = 0, sdata = 0, underrun = 0, sample_ready = 1.
  - div_cnt = 0, bit_cnt = 0, full = 0, F = 0.
- Reset asserted mid-frame aborts the frame and discards the held sample.
- First bclk rise: CLK_DIV clks after reset releases. First falling event: 2·CLK_DIV clks after release.
- First load event: bit_cnt 0→1. It occurs 2·CLK_DIV clks after release, at the first falling event.
- A sample accepted before the first load event appears as the left MSB on sdata at that load event.
- Latency from acceptance to sdata MSB is at most 128·CLK_DIV + 1 clks.
- sample_ready:
  - Falls on the clk edge after a transfer.
  - Rises on the clk edge of the load event that consumes the entry.
- At most one sample is accepted per frame in steady state.

## Test plan
- Reset: hold reset = 0 for 10 clks with random inputs → bclk = lrclk = sdata = underrun = 0 and sample_ready = 1 throughout. Release → first bclk rise after exactly CLK_DIV clks.
- Basic frame (CLK_DIV = 2, DATA_W = 24): send 32'h0012_3456 → left slot bits 1..32 are 0x123456 followed by 8 zeros. The right slot is identical. lrclk falls at bit_cnt 0 and rises at bit_cnt 32, and the BCLK period is 4 clks.
- Saturation with each of the following inputs → the 24-bit slot value shown:
  - 32'h7FFF_FFFF → 0x7FFFFF.
  - 32'h8000_0000 → 0x800000.
  - 32'hFFFF_FFFF → 0xFFFFFF.
  - 32'h0080_0000 → 0x7FFFFF.
- Underrun: no sample_valid for 3 frames → sdata stays 0 and underrun pulses exactly 3 times, one clk wide at each load event. Then send one sample → it is sent in the next frame and no further underrun occurs in that frame.
- Back-pressure: hold sample_valid high with samples A then B → A is accepted immediately and sample_ready stays low until the next load event. B is accepted on the following clk, and frames carry A then B in order with nothing lost.
- Reset mid-frame: assert reset at bit_cnt 20 with the holding register full → all outputs go to 0 the same cycle and sample_ready goes to 1. After release, the first frame sends zeros and underrun pulses once.

Source files
------------

// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter: one-deep sample holding register, BCLK/LRCLK generation,
// saturation to the codec width, and the same mono sample in both channel slots.
module i2s_tx_serializer #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        underrun
);

    localparam logic [7:0]         DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic signed [31:0] SAT_MAX  = 32'sh7FFF_FFFF >>> (32 - DATA_W);
    localparam logic signed [31:0] SAT_MIN  = 32'sh8000_0000 >>> (32 - DATA_W);

    logic [7:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic [5:0]  bit_next;
    logic        full;
    logic [31:0] hold;
    logic [63:0] frame;
    logic        div_wrap;
    logic        fall_evt;
    logic        load_evt;
    logic signed [31:0] hold_s;
    logic [31:0] sat_val;
    logic [31:0] slot;

    assign div_wrap     = (div_cnt == DIV_LAST);
    assign fall_evt     = div_wrap & bclk;
    assign load_evt     = fall_evt & (bit_cnt == 6'd0);
    assign bit_next     = bit_cnt + 6'd1;
    assign sample_ready = ~full;
    assign hold_s       = hold;

    // Saturate, then left-justify the DATA_W-bit value in a 32-bit slot.
    always_comb begin
        sat_val = hold;
        if (hold_s > SAT_MAX) begin
            sat_val = SAT_MAX;
        end else if (hold_s < SAT_MIN) begin
            sat_val = SAT_MIN;
        end
        slot = sat_val << (32 - DATA_W);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt  <= 8'd0;
            bclk     <= 1'b0;
            bit_cnt  <= 6'd0;
            lrclk    <= 1'b0;
            sdata    <= 1'b0;
            underrun <= 1'b0;
            frame    <= 64'd0;
            full     <= 1'b0;
            hold     <= 32'd0;
        end else begin
            underrun <= 1'b0;

            if (div_wrap) begin
                div_cnt <= 8'd0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end

            // frame holds the bits still to be sent, already advanced past sdata.
            if (fall_evt) begin
                bit_cnt <= bit_next;
                lrclk   <= bit_next[5];
                if (bit_cnt == 6'd0) begin
                    if (full) begin
                        sdata <= slot[31];
                        frame <= {slot[30:0], slot, 1'b0};
                    end else begin
                        sdata    <= 1'b0;
                        frame    <= 64'd0;
                        underrun <= 1'b1;
                    end
                end else begin
                    sdata <= frame[63];
                    frame <= {frame[62:0], 1'b0};
                end
            end

            // A load and a transfer never coincide: transfer needs empty, load-take needs full.
            if (load_evt && full) begin
                full <= 1'b0;
            end else if (sample_valid && !full) begin
                full <= 1'b1;
                hold <= sample_in;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: a negedge monitor rebuilds 64-bit frames from
// the serial stream while one initial block drives samples and checks results.
`timescale 1ns/1ps
module tb_i2s_tx_serializer;

    localparam int CLK_DIV = 2;
    localparam int DATA_W  = 24;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] sample_in = 32'd0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underrun;

    always #5 clk = ~clk;

    i2s_tx_serializer #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .underrun     (underrun)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Receiver model: bit index counted from bclk falling edges seen since reset release.
    logic [5:0]  mon_bit = 6'd0;
    logic        prev_bclk = 1'b0;
    logic        in_frame = 1'b0;
    logic [63:0] acc = 64'd0;
    logic        und_load = 1'b0;
    logic        is_fall;
    logic        is_load;
    logic [63:0] frame_q[$];
    logic        und_q[$];
    int          und_total = 0;
    int          lr_bad = 0;
    int          und_stray = 0;

    always @(negedge clk) begin
        if (!reset) begin
            mon_bit   = 6'd0;
            prev_bclk = 1'b0;
            in_frame  = 1'b0;
            acc       = 64'd0;
        end else begin
            is_fall = (prev_bclk === 1'b1) && (bclk === 1'b0);
            is_load = 1'b0;
            if (is_fall) begin
                mon_bit = mon_bit + 6'd1;
                if (lrclk !== mon_bit[5]) lr_bad++;
                if (mon_bit == 6'd1) begin
                    is_load  = 1'b1;
                    in_frame = 1'b1;
                    acc      = 64'd0;
                    und_load = underrun;
                end
                if (in_frame) acc = {acc[62:0], sdata};
                if (mon_bit == 6'd0 && in_frame) begin
                    frame_q.push_back(acc);
                    und_q.push_back(und_load);
                end
            end
            if (underrun === 1'b1) begin
                und_total++;
                if (!is_load) und_stray++;
            end
            prev_bclk = bclk;
        end
    end

    task automatic pop_frame(input string tag, input logic [63:0] exp_f, input logic exp_u);
        int n = 0;
        logic got;
        logic [63:0] f;
        logic u;
        while (frame_q.size() == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        got = (frame_q.size() != 0);
        chk({tag, "_timeout"}, 64'(got), 64'd1);
        if (got) begin
            f = frame_q.pop_front();
            u = und_q.pop_front();
            chk({tag, "_data"}, f, exp_f);
            chk({tag, "_underrun"}, 64'(u), 64'(exp_u));
        end
    endtask

    task automatic send(input logic [31:0] d);
        int n = 0;
        sample_in    = d;
        sample_valid = 1'b1;
        while (sample_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", 64'(sample_ready === 1'b1), 64'd1);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    int u0;
    int n;

    initial begin
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            sample_in    = $urandom;
            sample_valid = 1'($urandom_range(0, 1));
            chk("reset_outputs", 64'({bclk, lrclk, sdata, underrun, sample_ready}), 64'd1);
        end

        // Release with a sample waiting; it must be the first frame's content.
        sample_valid = 1'b1;
        sample_in    = 32'h0012_3456;
        reset        = 1'b1;
        @(negedge clk);
        chk("bclk_low_edge1", 64'(bclk), 64'd0);
        chk("ready_after_xfer", 64'(sample_ready), 64'd0);
        sample_valid = 1'b0;
        @(negedge clk);
        chk("bclk_first_rise", 64'(bclk), 64'd1);
        @(negedge clk);
        chk("ready_before_load", 64'(sample_ready), 64'd0);
        @(negedge clk);
        chk("bclk_first_fall", 64'(bclk), 64'd0);
        chk("ready_at_load", 64'(sample_ready), 64'd1);
        chk("first_msb", 64'(sdata), 64'd0);
        chk("no_underrun_first", 64'(underrun), 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk("bclk_period", 64'(bclk), 64'd1);

        send(32'h7FFF_FFFF);
        send(32'h8000_0000);
        send(32'hFFFF_FFFF);
        send(32'h0080_0000);
        pop_frame("basic", 64'h12345600_12345600, 1'b0);
        pop_frame("sat_max", 64'h7FFFFF00_7FFFFF00, 1'b0);
        pop_frame("sat_min", 64'h80000000_80000000, 1'b0);
        pop_frame("minus_one", 64'hFFFFFF00_FFFFFF00, 1'b0);
        pop_frame("sat_pos", 64'h7FFFFF00_7FFFFF00, 1'b0);

        u0 = und_total;
        pop_frame("under1", 64'd0, 1'b1);
        pop_frame("under2", 64'd0, 1'b1);
        pop_frame("under3", 64'd0, 1'b1);
        chk("underrun_count", 64'(und_total - u0), 64'd3);
        send(32'h000A_BCDE);
        pop_frame("after_under", 64'h0ABCDE00_0ABCDE00, 1'b0);
        chk("underrun_count_after", 64'(und_total - u0), 64'd3);

        // Back-pressure: A accepted at once, B held until the next load frees the entry.
        sample_in    = 32'hFFF0_0001;
        sample_valid = 1'b1;
        chk("bp_ready_a", 64'(sample_ready), 64'd1);
        @(negedge clk);
        chk("bp_ready_low", 64'(sample_ready), 64'd0);
        sample_in = 32'h0000_0100;
        n = 0;
        while (sample_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("bp_ready_rise", 64'(sample_ready), 64'd1);
        chk("bp_load_no_underrun", 64'(underrun), 64'd0);
        @(negedge clk);
        chk("bp_b_accepted", 64'(sample_ready), 64'd0);
        sample_valid = 1'b0;
        pop_frame("bp_a", 64'hF0000100_F0000100, 1'b0);
        pop_frame("bp_b", 64'h00010000_00010000, 1'b0);

        // Reset mid-frame with the holding register full.
        send(32'h1111_1111);
        send(32'h2222_2222);
        n = 0;
        while (mon_bit != 6'd20 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("reach_bit20", 64'(mon_bit), 64'd20);
        chk("full_before_reset", 64'(sample_ready), 64'd0);
        reset = 1'b0;
        #1;
        chk("midframe_reset_outputs", 64'({bclk, lrclk, sdata, underrun, sample_ready}), 64'd1);
        repeat (3) @(negedge clk);
        u0    = und_total;
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 64'(sample_ready), 64'd1);
        pop_frame("post_reset", 64'd0, 1'b1);
        chk("post_reset_underruns", 64'(und_total - u0), 64'd1);

        chk("lrclk_alignment", 64'(lr_bad), 64'd0);
        chk("stray_underrun", 64'(und_stray), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
